mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LATENCY, default 2, memory access cycles per transaction (legal 1..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a_memreqM  input  1  core A memory-stage load/store request (level).
REQ-005 a_memwriteM  input  1  core A request is a store.
REQ-006 a_addrM, a_wdataM  input  32 each  core A address and store data.
REQ-007 a_rdataM  output  32  core A load data.
REQ-008 a_stallM  output  1  freeze core A fetch through memory stages.
REQ-009 b_memreqM, b_memwriteM, b_addrM, b_wdataM, b_rdataM, b_stallM: core B equivalents, same widths and directions.
REQ-010 mem_en  output  1  shared data memory enable.
REQ-011 mem_we  output  1  shared data memory write enable.
REQ-012 mem_addr, mem_wdata  output  32 each  shared memory address and write data.
REQ-013 mem_rdata  input  32  memory read data, valid in the final access cycle.

Function
REQ-014 FSM states IDLE, BUSY_A, BUSY_B; 4-bit down-counter cnt; 1-bit last_grant (0=A, 1=B).
REQ-015 IDLE, only one core requesting: grant it, load cnt=MEM_LATENCY-1, enter BUSY_x next cycle.
REQ-016 IDLE, both requesting: grant the core not equal to last_grant (round-robin).
REQ-017 On every grant, latch requester's address, write data and write flag; set last_grant to the grantee.
REQ-018 BUSY_x: mem_en=1; mem_we, mem_addr, mem_wdata driven from latched values, held stable for the whole transaction.
REQ-019 BUSY_x with cnt!=0: decrement cnt; stay in BUSY_x.
REQ-020 BUSY_x with cnt==0 is the done cycle: transaction completes; owner's current request counts as served.
REQ-021 Done cycle next state: other core requesting -> grant it directly (BUSY_other, no IDLE bubble, REQ-017 applies); otherwise IDLE.
REQ-022 Owner's request is never re-granted from its own done cycle.
REQ-023 x_stallM = x_memreqM AND NOT (state==BUSY_x AND cnt==0); combinational.
REQ-024 Request to grant latency: request first seen in IDLE at cycle t -> mem_en cycles t+1..t+MEM_LATENCY -> stall low in cycle t+MEM_LATENCY.
REQ-025 Load done cycle: x_rdataM = mem_rdata combinationally; same value captured into a per-core hold register.
REQ-026 Outside own load done cycle, x_rdataM = that core's hold register; stores do not update it.
REQ-027 Request dropped mid-transaction: transaction still runs to completion, memory signals unchanged; no rdata effect on other core.
REQ-028 IDLE, or mem_en low: mem_we=0; mem_addr, mem_wdata = 0.
REQ-029 No transaction ever touches the other core's hold register or stall.

Reset
REQ-030 While reset high, and immediately on assertion: state=IDLE, cnt=0, last_grant=1 (B), hold registers=0, latches=0.
REQ-031 Reset mid-transaction: transaction abandoned; mem_en low same cycle; no write completes after reset.
REQ-032 During reset x_stallM follows x_memreqM; mem_en, mem_we=0; x_rdataM=0.
REQ-033 First contention after reset grants core A.

Verification (MEM_LATENCY=2 unless stated)
REQ-034 A load 0x100, mem_rdata=0xDEADBEEF -> mem_en cycles 1-2, a_stallM 1,1,0; a_rdataM=0xDEADBEEF at cycle 2 and after.
REQ-035 A and B request together after reset -> A served cycles 1-2, B cycles 3-4 back-to-back; b_stallM high cycles 0-3.
REQ-036 Both held continuously over 4 transactions -> grant order A,B,A,B; never same core twice in a row.
REQ-037 B store 0x200 data 0x12345678, MEM_LATENCY=1 -> one cycle mem_en=mem_we=1, addr 0x200; b_stallM low that cycle; b_rdataM unchanged.
REQ-038 Reset asserted in first BUSY_A cycle -> mem_en=0 at once; after release, idle; next A request takes full MEM_LATENCY.
REQ-039 A request dropped after grant, cnt=1 -> mem_addr stable until done; then IDLE; a_stallM low throughout drop.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that lets two pipelined cores share one data memory port.
// Each transaction occupies the memory for MEM_LATENCY cycles. The final (done)
// cycle releases the owner's stall and, for loads, forwards mem_rdata and also
// captures it into that core's hold register.
//
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   a_memreqM/a_memwriteM         - core A request level and store flag
//   a_addrM/a_wdataM              - core A address and store data
//   a_rdataM/a_stallM             - core A load data and pipeline stall
//   b_*                           - core B equivalents
//   mem_en/mem_we                 - shared memory enable and write enable
//   mem_addr/mem_wdata/mem_rdata  - shared memory address, write and read data
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_memreqM,
  input  logic        a_memwriteM,
  input  logic [31:0] a_addrM,
  input  logic [31:0] a_wdataM,
  output logic [31:0] a_rdataM,
  output logic        a_stallM,
  input  logic        b_memreqM,
  input  logic        b_memwriteM,
  input  logic [31:0] b_addrM,
  input  logic [31:0] b_wdataM,
  output logic [31:0] b_rdataM,
  output logic        b_stallM,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusyA, StBusyB} state_e;

  localparam logic [3:0] CntInit = 4'(MEM_LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;  // 0 = A, 1 = B
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic        lat_we_q, lat_we_d;
  logic [31:0] hold_a_q, hold_b_q;

  logic grant_a, grant_b;
  logic busy, a_done, b_done, a_load_done, b_load_done;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_we_d     = lat_we_q;
    grant_a      = 1'b0;
    grant_b      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (a_memreqM && b_memreqM) begin
          // Contention: favour whichever core was not granted last.
          if (last_grant_q) grant_a = 1'b1;
          else              grant_b = 1'b1;
        end else if (a_memreqM) begin
          grant_a = 1'b1;
        end else if (b_memreqM) begin
          grant_b = 1'b1;
        end
      end
      StBusyA: begin
        // The owner's request is served in its done cycle, so only the other
        // core may be granted straight from here.
        if (cnt_q != 4'd0)  cnt_d   = cnt_q - 4'd1;
        else if (b_memreqM) grant_b = 1'b1;
        else                state_d = StIdle;
      end
      StBusyB: begin
        if (cnt_q != 4'd0)  cnt_d   = cnt_q - 4'd1;
        else if (a_memreqM) grant_a = 1'b1;
        else                state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (grant_a) begin
      state_d      = StBusyA;
      cnt_d        = CntInit;
      last_grant_d = 1'b0;
      lat_addr_d   = a_addrM;
      lat_wdata_d  = a_wdataM;
      lat_we_d     = a_memwriteM;
    end
    if (grant_b) begin
      state_d      = StBusyB;
      cnt_d        = CntInit;
      last_grant_d = 1'b1;
      lat_addr_d   = b_addrM;
      lat_wdata_d  = b_wdataM;
      lat_we_d     = b_memwriteM;
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    a_done      = (state_q == StBusyA) && (cnt_q == 4'd0);
    b_done      = (state_q == StBusyB) && (cnt_q == 4'd0);
    a_load_done = a_done && !lat_we_q;
    b_load_done = b_done && !lat_we_q;

    a_stallM    = a_memreqM && !a_done;
    b_stallM    = b_memreqM && !b_done;
    a_rdataM    = a_load_done ? mem_rdata : hold_a_q;
    b_rdataM    = b_load_done ? mem_rdata : hold_b_q;

    mem_en      = busy;
    mem_we      = busy && lat_we_q;
    mem_addr    = busy ? lat_addr_q  : 32'd0;
    mem_wdata   = busy ? lat_wdata_q : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;  // first contention after reset goes to A
      lat_addr_q   <= 32'd0;
      lat_wdata_q  <= 32'd0;
      lat_we_q     <= 1'b0;
      hold_a_q     <= 32'd0;
      hold_b_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_we_q     <= lat_we_d;
      if (a_load_done) hold_a_q <= mem_rdata;
      if (b_load_done) hold_b_q <= mem_rdata;
    end
  end

endmodule
